// File: rtl/hps_pio_gen.sv
// rtl/hps_pio_gen.sv - Avalon-MM parallel I/O port with set/clear/toggle and sticky edge capture
// Inputs are double-synchronised before edge detection; edge capture beats a same-cycle clear.
module hps_pio_gen #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLEAR  = 3'd2;
  localparam logic [2:0] A_TOGGLE = 3'd3;
  localparam logic [2:0] A_IN     = 3'd4;
  localparam logic [2:0] A_MASK   = 3'd5;
  localparam logic [2:0] A_ECAP   = 3'd6;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] wd, clr_w, rise_w, fall_w, edge_w, rd_w;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  assign rise_w = sync2_q & ~prev_q;
  assign fall_w = ~sync2_q & prev_q;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_w = rise_w;
      1:       edge_w = fall_w;
      default: edge_w = rise_w | fall_w;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr_w  = '0;
    if (wr) begin
      case (address)
        A_DATA:   out_d  = wd;
        A_SET:    out_d  = out_q | wd;
        A_CLEAR:  out_d  = out_q & ~wd;
        A_TOGGLE: out_d  = out_q ^ wd;
        A_MASK:   mask_d = wd;
        A_ECAP:   clr_w  = wd;
        default:  ;
      endcase
    end
    // Newly detected edges are OR-ed in after the clear so they are never lost.
    ecap_d = (ecap_q & ~clr_w) | edge_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= RESET_VALUE;
      mask_q  <= '0;
      ecap_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      ecap_q  <= ecap_d;
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    case (address)
      A_DATA:  rd_w = out_q;
      A_IN:    rd_w = sync2_q;
      A_MASK:  rd_w = mask_q;
      A_ECAP:  rd_w = ecap_q;
      default: rd_w = '0;
    endcase
    readdata            = '0;
    readdata[WIDTH-1:0] = rd_w;
  end

  assign out_port = out_q;
  assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_hps_pio_gen.sv
// tb/tb_hps_pio_gen.sv - randomized and directed checks of hps_pio_gen against a history-based model
module tb_hps_pio_gen;

  logic clk = 1'b0;
  logic reset;

  logic [2:0]  a8;
  logic        cs8, wn8;
  logic [31:0] wd8, rd8;
  logic [7:0]  in8, out8;
  logic        irq8;

  logic [2:0]  a32;
  logic        cs32, wn32;
  logic [31:0] wd32, rd32, in32, out32;
  logic        irq32;

  int checks = 0;
  int errors = 0;

  // reference model state for the 8-bit rising-edge instance
  logic [7:0] m_out, m_mask, m_ecap;
  logic [7:0] hist [0:2];

  hps_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)) dut8 (
    .clk(clk), .reset(reset), .address(a8), .chipselect(cs8), .write_n(wn8),
    .writedata(wd8), .readdata(rd8), .in_port(in8), .out_port(out8), .irq(irq8)
  );

  hps_pio_gen #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) dut32 (
    .clk(clk), .reset(reset), .address(a32), .chipselect(cs32), .write_n(wn32),
    .writedata(wd32), .readdata(rd32), .in_port(in32), .out_port(out32), .irq(irq32)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out  = 8'hA5;
    m_mask = 8'h00;
    m_ecap = 8'h00;
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] addr);
    case (addr)
      3'd0:    return {24'h0, m_out};
      3'd4:    return {24'h0, hist[1]};
      3'd5:    return {24'h0, m_mask};
      3'd6:    return {24'h0, m_ecap};
      default: return 32'h0;
    endcase
  endfunction

  // hist[0] = input seen at last edge, hist[1] = two edges ago (visible value), hist[2] = three ago
  task automatic model_step(input logic wr, input logic [2:0] addr, input logic [7:0] wd, input logic [7:0] inv);
    logic [7:0] rise;
    rise = hist[1] & ~hist[2];
    if (wr) begin
      case (addr)
        3'd0: m_out = wd;
        3'd1: m_out = m_out | wd;
        3'd2: m_out = m_out & ~wd;
        3'd3: m_out = m_out ^ wd;
        3'd5: m_mask = wd;
        3'd6: m_ecap = m_ecap & ~wd;
        default: ;
      endcase
    end
    m_ecap  = m_ecap | rise;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = inv;
  endtask

  task automatic tick8();
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wd, inv;
    wr = cs8 && !wn8; addr = a8; wd = wd8[7:0]; inv = in8;
    @(posedge clk);
    model_step(wr, addr, wd, inv);
    #1;
    check_eq("out_port8", {24'h0, out8}, {24'h0, m_out});
    check_eq("irq8", {31'h0, irq8}, {31'h0, |(m_ecap & m_mask)});
  endtask

  task automatic wr8(input logic [2:0] addr, input logic [31:0] data);
    a8 = addr; wd8 = data; cs8 = 1'b1; wn8 = 1'b0;
    tick8();
    cs8 = 1'b0; wn8 = 1'b1;
  endtask

  task automatic rd8_check(input string tag, input logic [2:0] addr);
    a8 = addr; cs8 = 1'b1; wn8 = 1'b1;
    #1;
    check_eq(tag, rd8, model_read(addr));
    cs8 = 1'b0;
  endtask

  task automatic tick32();
    @(posedge clk);
    #1;
  endtask

  task automatic wr32(input logic [2:0] addr, input logic [31:0] data);
    a32 = addr; wd32 = data; cs32 = 1'b1; wn32 = 1'b0;
    tick32();
    cs32 = 1'b0; wn32 = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    a8 = 3'd0; cs8 = 1'b0; wn8 = 1'b1; wd8 = 32'h0; in8 = 8'h00;
    a32 = 3'd0; cs32 = 1'b0; wn32 = 1'b1; wd32 = 32'h0; in32 = 32'h0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_eq("rst_out_port", {24'h0, out8}, 32'h000000A5);
    check_eq("rst_irq", {31'h0, irq8}, 32'h0);
    a8 = 3'd0; cs8 = 1'b1;
    #1;
    check_eq("rst_read_data", rd8, 32'h000000A5);
    cs8 = 1'b0;
    check_eq("rst_out_port32", out32, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // data / set / clear / toggle sequence
    wr8(3'd0, 32'h0000000F);
    check_eq("data_0f", {24'h0, out8}, 32'h0F);
    wr8(3'd1, 32'hFFFFFFF0);
    check_eq("set_f0", {24'h0, out8}, 32'hFF);
    wr8(3'd2, 32'h00000003);
    check_eq("clear_03", {24'h0, out8}, 32'hFC);
    wr8(3'd3, 32'h000000FF);
    check_eq("toggle_ff", {24'h0, out8}, 32'h03);
    rd8_check("rd_set_zero", 3'd1);
    rd8_check("rd_rsvd_zero", 3'd7);

    // rising edge on bit 0 shows up three edges later
    wr8(3'd5, 32'h01);
    in8 = 8'h01;
    tick8();
    rd8_check("ecap_lat1", 3'd6);
    tick8();
    check_eq("ecap_lat2", rd8, 32'h0);
    rd8_check("ecap_lat2_model", 3'd6);
    tick8();
    rd8_check("ecap_lat3", 3'd6);
    check_eq("ecap_set", rd8, 32'h01);
    check_eq("irq_set", {31'h0, irq8}, 32'h1);
    wr8(3'd6, 32'h01);
    check_eq("irq_clr", {31'h0, irq8}, 32'h0);

    // clear lands on the same edge that detects a new bit-2 rise
    in8 = 8'h05;
    tick8();
    tick8();
    wr8(3'd6, 32'h04);
    rd8_check("ecap_race", 3'd6);
    check_eq("ecap_race_bit2", rd8 & 32'h04, 32'h04);
    wr8(3'd6, 32'h04);
    rd8_check("ecap_clr2", 3'd6);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) in8 = 8'($urandom);
      if ($urandom_range(0, 1) == 0) wr8(3'($urandom), $urandom);
      else tick8();
      rd8_check("rand_read", 3'($urandom));
    end

    // asynchronous reset mid-cycle, then first-capture-after-reset
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("async_out", {24'h0, out8}, 32'hA5);
    check_eq("async_irq", {31'h0, irq8}, 32'h0);
    rd8_check("async_ecap", 3'd6);
    rd8_check("async_mask", 3'd5);
    rd8_check("async_in", 3'd4);
    in8 = 8'hFF;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick8();
    rd8_check("first_cap", 3'd6);
    check_eq("first_cap_ff", rd8, 32'hFF);

    // 32-bit any-edge instance
    wr32(3'd0, 32'hDEADBEEF);
    check_eq("out32_full", out32, 32'hDEADBEEF);
    in32 = 32'h80000000;
    repeat (2) tick32();
    in32 = 32'h0;
    repeat (4) tick32();
    a32 = 3'd6; cs32 = 1'b1;
    #1;
    check_eq("ecap32_bit31", rd32, 32'h80000000);
    check_eq("irq32_masked", {31'h0, irq32}, 32'h0);
    cs32 = 1'b0;
    wr32(3'd5, 32'h80000000);
    check_eq("irq32_unmasked", {31'h0, irq32}, 32'h1);
    wr32(3'd6, 32'h80000000);
    check_eq("irq32_cleared", {31'h0, irq32}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
